// File: rtl/simple_proc_core.sv
// Multi-cycle 8-register processor core: mv / mvi / add / sub over a shared bus,
// sequenced by a four-state T0..T3 controller.
module simple_proc_core #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] DIN,
  input  logic              Run,
  input  logic [2:0]        RegSel,
  output logic              Done,
  output logic [DATA_W-1:0] BusWires,
  output logic [DATA_W-1:0] RegView
);

  localparam int unsigned IR_W  = 9;
  localparam int unsigned NREGS = 8;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  state_t            state_q, state_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] g_q, g_d;
  logic [DATA_W-1:0] bus_q, bus_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              done_c;

  logic [2:0] op, rx, ry;
  assign op = ir_q[8:6];
  assign rx = ir_q[5:3];
  assign ry = ir_q[2:0];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= T0;
      ir_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
      bus_q   <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      g_q     <= g_d;
      bus_q   <= bus_d;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Next-state, datapath transfers and Done decode (Done depends only on state and IR).
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    a_d     = a_q;
    g_d     = g_q;
    bus_d   = bus_q;
    regs_d  = regs_q;
    done_c  = 1'b0;
    case (state_q)
      T0: begin
        if (Run) begin
          ir_d    = DIN[IR_W-1:0];
          state_d = T1;
        end
      end
      T1: begin
        case (op)
          OP_MV: begin
            regs_d[rx] = regs_q[ry];
            bus_d      = regs_q[ry];
            done_c     = 1'b1;
            state_d    = T0;
          end
          OP_MVI: begin
            regs_d[rx] = DIN;
            bus_d      = DIN;
            done_c     = 1'b1;
            state_d    = T0;
          end
          OP_ADD, OP_SUB: begin
            a_d     = regs_q[rx];
            bus_d   = regs_q[rx];
            state_d = T2;
          end
          default: begin
            done_c  = 1'b1;
            state_d = T0;
          end
        endcase
      end
      T2: begin
        g_d     = (op == OP_SUB) ? DATA_W'(a_q - regs_q[ry]) : DATA_W'(a_q + regs_q[ry]);
        bus_d   = regs_q[ry];
        state_d = T3;
      end
      T3: begin
        regs_d[rx] = g_q;
        bus_d      = g_q;
        done_c     = 1'b1;
        state_d    = T0;
      end
      default: state_d = T0;
    endcase
  end

  assign Done     = done_c;
  assign BusWires = bus_q;
  assign RegView  = regs_q[RegSel];

endmodule

// File: tb/tb_simple_proc_core.sv
// Directed self-checking bench for simple_proc_core with hand-computed expectations.
module tb_simple_proc_core;

  localparam int unsigned DATA_W = 16;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_UND = 3'b101;

  logic              Clock;
  logic              Reset;
  logic [DATA_W-1:0] DIN;
  logic              Run;
  logic [2:0]        RegSel;
  logic              Done;
  logic [DATA_W-1:0] BusWires;
  logic [DATA_W-1:0] RegView;

  int checks   = 0;
  int failures = 0;

  simple_proc_core #(.DATA_W(DATA_W)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .DIN     (DIN),
    .Run     (Run),
    .RegSel  (RegSel),
    .Done    (Done),
    .BusWires(BusWires),
    .RegView (RegView)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] r, input logic [DATA_W-1:0] exp);
    @(negedge Clock);
    RegSel = r;
    #1 check(tag, 32'(RegView), 32'(exp));
  endtask

  // Issue one instruction; imm is presented on DIN during T1. Waits (bounded) for Done.
  task automatic issue(input string tag, input logic [2:0] op, input logic [2:0] x,
                       input logic [2:0] y, input logic [DATA_W-1:0] imm, input int exp_lat);
    int lat;
    lat = 0;
    @(negedge Clock);
    Run = 1'b1;
    DIN = {7'b0, op, x, y};
    @(posedge Clock);
    #1;
    Run = 1'b0;
    DIN = imm;
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      @(negedge Clock);
      if (Done) lat = c;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (lat != 0) @(posedge Clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] exp_regs [8];
    logic              done_pat [7];
    Reset  = 1'b1;
    Run    = 1'b0;
    DIN    = '0;
    RegSel = 3'd0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    check("rst_done", 32'(Done), 32'(0));
    check("rst_bus", 32'(BusWires), 32'(0));
    for (int r = 0; r < 8; r++) chk_reg("rst_reg", 3'(r), 16'd0);

    // Test 1: mvi / add / sub sequence
    issue("mvi_r0", OP_MVI, 3'd0, 3'd0, 16'd10, 1);
    check("bus_mvi", 32'(BusWires), 32'd10);
    issue("mvi_r7", OP_MVI, 3'd7, 3'd0, 16'd20, 1);
    issue("add_r0r7", OP_ADD, 3'd0, 3'd7, 16'h0000, 3);
    check("bus_add", 32'(BusWires), 32'd30);
    chk_reg("r0_add", 3'd0, 16'd30);
    issue("mvi_r2", OP_MVI, 3'd2, 3'd0, 16'd4, 1);
    issue("sub_r0r2", OP_SUB, 3'd0, 3'd2, 16'h0000, 3);
    chk_reg("r0_sub", 3'd0, 16'd26);

    // Test 6: RegView sweep
    exp_regs = '{16'd26, 16'd0, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0, 16'd20};
    for (int r = 0; r < 8; r++) chk_reg("regview", 3'(r), exp_regs[r]);

    // Test 4: mv and undefined opcode
    issue("mv_r3r0", OP_MV, 3'd3, 3'd0, 16'h0000, 1);
    check("bus_mv", 32'(BusWires), 32'd26);
    chk_reg("r3_mv", 3'd3, 16'd26);
    issue("nop", OP_UND, 3'd3, 3'd7, 16'h1234, 1);
    chk_reg("r3_nop", 3'd3, 16'd26);
    chk_reg("r0_nop", 3'd0, 16'd26);
    check("bus_nop", 32'(BusWires), 32'd26);

    // Test 2: wraparound
    issue("mvi_r0z", OP_MVI, 3'd0, 3'd0, 16'd0, 1);
    issue("mvi_r1", OP_MVI, 3'd1, 3'd0, 16'd1, 1);
    issue("sub_wrap", OP_SUB, 3'd0, 3'd1, 16'h0000, 3);
    chk_reg("r0_ffff", 3'd0, 16'hFFFF);
    check("bus_ffff", 32'(BusWires), 32'hFFFF);
    issue("add_wrap", OP_ADD, 3'd0, 3'd1, 16'h0000, 3);
    chk_reg("r0_wrap0", 3'd0, 16'd0);

    // X==Y cases
    issue("mvi_r4", OP_MVI, 3'd4, 3'd0, 16'd7, 1);
    issue("add_r4r4", OP_ADD, 3'd4, 3'd4, 16'h0000, 3);
    chk_reg("r4_dbl", 3'd4, 16'd14);
    issue("sub_r4r4", OP_SUB, 3'd4, 3'd4, 16'h0000, 3);
    chk_reg("r4_zero", 3'd4, 16'd0);
    issue("mv_r3r3", OP_MV, 3'd3, 3'd3, 16'h0000, 1);
    chk_reg("r3_self", 3'd3, 16'd26);

    // Test 3: Run held high for 5 edges with add R0,R7 (R0=5, R7=20)
    issue("mvi_r0_5", OP_MVI, 3'd0, 3'd0, 16'd5, 1);
    done_pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    @(negedge Clock);
    RegSel = 3'd0;
    Run    = 1'b1;
    DIN    = {7'b0, OP_ADD, 3'd0, 3'd7};
    for (int e = 0; e < 7; e++) begin
      @(posedge Clock);
      @(negedge Clock);
      check("held_done", 32'(Done), 32'(done_pat[e]));
      if (e == 3) check("held_r0_first", 32'(RegView), 32'd25);
      if (e == 4) begin
        Run = 1'b0;
        DIN = '0;
      end
    end
    @(posedge Clock);
    chk_reg("held_r0_second", 3'd0, 16'd45);

    // Test 5: reset while in T2 of add R6,R6
    issue("mvi_r6", OP_MVI, 3'd6, 3'd0, 16'd9, 1);
    @(negedge Clock);
    Run = 1'b1;
    DIN = {7'b0, OP_ADD, 3'd6, 3'd6};
    @(posedge Clock);
    #1 Run = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    RegSel = 3'd6;
    #1 check("pre_rst_r6", 32'(RegView), 32'd9);
    Reset = 1'b1;
    #1;
    check("midrst_done", 32'(Done), 32'(0));
    check("midrst_r6", 32'(RegView), 32'd0);
    check("midrst_bus", 32'(BusWires), 32'd0);
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clock);
      check("post_rst_done", 32'(Done), 32'(0));
    end
    for (int r = 0; r < 8; r++) chk_reg("post_rst_reg", 3'(r), 16'd0);

    // Core still operational after reset
    issue("mvi_post", OP_MVI, 3'd5, 3'd0, 16'hBEEF, 1);
    chk_reg("r5_post", 3'd5, 16'hBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
